// File: rtl/neighbor_table_writer.sv
// Appends or updates (neighborID, clusterID) records in the shared-memory neighbor table.
// Build option: define NEIGHBOR_DEDUP_EN to scan for and update existing neighborIDs in place.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module neighbor_table_writer (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [`WORD_WIDTH-1:0]  in_neighbor_id,
   input  logic [`WORD_WIDTH-1:0]  in_cluster_id,
   output logic [15:0]             address,
   input  logic [`WORD_WIDTH-1:0]  data_in,
   output logic [`WORD_WIDTH-1:0]  data_out,
   output logic                    write_en,
   output logic [6:0]              neighbor_count,
   output logic                    table_full,
   output logic                    done,
   output logic                    hit,
   output logic                    drop
);

   localparam int W = `WORD_WIDTH;
   localparam logic [15:0] NID_BASE = 16'h0048;
   localparam logic [15:0] CID_BASE = 16'h00C8;

   typedef enum logic [2:0] {
      IDLE, SCAN_RD, SCAN_CMP, WR_UPD, WR_NID, WR_CID, DONE
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   nid_q, nid_d, cid_q, cid_d;
   logic [6:0]     i_q, i_d, count_q, count_d;
   logic [15:0]    addr_q, addr_d;
   logic [W-1:0]   dout_q, dout_d;
   logic           we_q, we_d, ready_q, ready_d, full_q, full_d;
   logic           done_q, done_d, hit_q, hit_d, drop_q, drop_d;

`ifndef NEIGHBOR_DEDUP_EN
   logic unused_data_in;
   assign unused_data_in = ^data_in;
`endif

   function automatic logic [15:0] slot_addr(input logic [15:0] base, input logic [6:0] idx);
      return base + {8'd0, idx, 1'b0};
   endfunction

   always_comb begin
      state_d = state_q;
      nid_d   = nid_q;
      cid_d   = cid_q;
      i_d     = i_q;
      count_d = count_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      hit_d   = 1'b0;
      drop_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               nid_d = in_neighbor_id;
               cid_d = in_cluster_id;
               i_d   = 7'd0;
`ifdef NEIGHBOR_DEDUP_EN
               if (count_q != 7'd0) state_d = SCAN_RD;
               else                 state_d = WR_NID;
`else
               if (full_q) begin
                  state_d = DONE;
                  drop_d  = 1'b1;
               end else begin
                  state_d = WR_NID;
               end
`endif
            end
         end
`ifdef NEIGHBOR_DEDUP_EN
         SCAN_RD: state_d = SCAN_CMP;
         SCAN_CMP: begin
            // data_in here is the entry addressed during the preceding SCAN_RD
            if (data_in == nid_q) begin
               state_d = WR_UPD;
            end else begin
               i_d = i_q + 7'd1;
               if (i_d == count_q) begin
                  if (full_q) begin
                     state_d = DONE;
                     drop_d  = 1'b1;
                  end else begin
                     state_d = WR_NID;
                  end
               end else begin
                  state_d = SCAN_RD;
               end
            end
         end
         WR_UPD: begin
            state_d = DONE;
            hit_d   = 1'b1;
         end
`endif
         WR_NID: state_d = WR_CID;
         WR_CID: begin
            state_d = DONE;
            count_d = count_q + 7'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the state being entered so they line up with it
      case (state_d)
         SCAN_RD: addr_d = slot_addr(NID_BASE, i_d);
         WR_UPD: begin
            addr_d = slot_addr(CID_BASE, i_d);
            dout_d = cid_d;
            we_d   = 1'b1;
         end
         WR_NID: begin
            addr_d = slot_addr(NID_BASE, count_d);
            dout_d = nid_d;
            we_d   = 1'b1;
         end
         WR_CID: begin
            addr_d = slot_addr(CID_BASE, count_d);
            dout_d = cid_d;
            we_d   = 1'b1;
         end
         DONE:    done_d = 1'b1;
         default: ;
      endcase

      ready_d = (state_d == IDLE);
      full_d  = (count_d == 7'd64);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         i_q     <= 7'd0;
         count_q <= 7'd0;
         addr_q  <= NID_BASE;
         dout_q  <= '0;
         we_q    <= 1'b0;
         ready_q <= 1'b1;
         full_q  <= 1'b0;
         done_q  <= 1'b0;
         hit_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         we_q    <= we_d;
         ready_q <= ready_d;
         full_q  <= full_d;
         done_q  <= done_d;
         hit_q   <= hit_d;
         drop_q  <= drop_d;
      end
   end

   always_ff @(posedge clock) begin
      nid_q <= nid_d;
      cid_q <= cid_d;
   end

   assign in_ready       = ready_q;
   assign address        = addr_q;
   assign data_out       = dout_q;
   assign write_en       = we_q;
   assign neighbor_count = count_q;
   assign table_full     = full_q;
   assign done           = done_q;
   assign hit            = hit_q;
   assign drop           = drop_q;

endmodule
